// File: rtl/shifter_seq_pkg.sv
// Shared types for the shifter command sequencer.
// Opcodes, FSM states and default argument width.
package shifter_seq_pkg;

  localparam int ARG_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_SET_DELAY = 3'd1,
    OP_SET_EVENT = 3'd2,
    OP_SET_POL   = 3'd3,
    OP_PULSE_RST = 3'd4,
    OP_WAIT      = 3'd5,
    OP_RSVD      = 3'd6,
    OP_END       = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_WAIT = 3'd2,
    S_RST  = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/shifter_cmd_fifo.sv
// Command FIFO for the shifter sequencer.
// Synchronous, with flush and occupancy output.
module shifter_cmd_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign level   = cnt;

  // Pointer and occupancy bookkeeping; flush empties in one cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/shifter_cmd_sequencer.sv
// Replays queued configuration commands onto a SignalShifter.
// One pop per RUN cycle; strobes appear the cycle after the pop.
module shifter_cmd_sequencer
  import shifter_seq_pkg::*;
#(
  parameter int MAX_DELAY   = 1000000000,
  parameter int DELAY_WIDTH = $clog2(MAX_DELAY),
  parameter int MAX_EVENT   = 10,
  parameter int EVENT_WIDTH = $clog2(MAX_EVENT),
  parameter int FIFO_DEPTH  = 16,
  parameter int ARG_WIDTH   = ARG_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  input  logic [2:0]                    cmd_opcode,
  input  logic [ARG_WIDTH-1:0]          cmd_arg,
  output logic                          cmd_ready,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          err_sticky,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          shifter_reset,
  output logic [DELAY_WIDTH-1:0]        delay_value,
  output logic                          delay_set,
  output logic [EVENT_WIDTH-1:0]        event_value,
  output logic                          event_set,
  output logic                          event_polarity_set
);

  localparam int FW = 3 + ARG_WIDTH;
  localparam logic [ARG_WIDTH-1:0] MAX_D = ARG_WIDTH'(MAX_DELAY);
  localparam logic [ARG_WIDTH-1:0] MAX_E = ARG_WIDTH'(MAX_EVENT);

  state_e                 state_q, state_d;
  logic [ARG_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   pop;
  logic                   push;
  logic                   f_empty;
  logic                   f_full;
  logic [FW-1:0]          f_data;
  opcode_e                f_op;
  logic [ARG_WIDTH-1:0]   f_arg;

  logic                   busy_d, done_d, err_d, srst_d;
  logic                   dset_d, eset_d, pol_d;
  logic [DELAY_WIDTH-1:0] dval_d;
  logic [EVENT_WIDTH-1:0] eval_d;

  assign cmd_ready = !f_full;
  assign push      = cmd_valid && !f_full && !abort;
  assign f_op      = opcode_e'(f_data[FW-1 -: 3]);
  assign f_arg     = f_data[ARG_WIDTH-1:0];

  shifter_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (abort),
    .push  (push),
    .wdata ({cmd_opcode, cmd_arg}),
    .pop   (pop),
    .rdata (f_data),
    .empty (f_empty),
    .full  (f_full),
    .level (fifo_level)
  );

  // Next-state, pop decision and next values of every registered output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    srst_d  = 1'b0;
    dset_d  = 1'b0;
    eset_d  = 1'b0;
    pol_d   = 1'b0;
    err_d   = err_sticky;
    dval_d  = delay_value;
    eval_d  = event_value;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      srst_d  = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RUN;
            err_d   = 1'b0;
          end
        end
        S_RUN: begin
          if (!f_empty) begin
            pop = 1'b1;
            unique case (f_op)
              OP_SET_DELAY: begin
                if (f_arg <= MAX_D) begin
                  dval_d = f_arg[DELAY_WIDTH-1:0];
                  dset_d = 1'b1;
                end else begin
                  err_d = 1'b1;
                end
              end
              OP_SET_EVENT: begin
                if (f_arg <= MAX_E) begin
                  eval_d = f_arg[EVENT_WIDTH-1:0];
                  eset_d = 1'b1;
                end else begin
                  err_d = 1'b1;
                end
              end
              OP_SET_POL: pol_d = 1'b1;
              OP_PULSE_RST: begin
                state_d = S_RST;
                cnt_d   = (f_arg == '0) ? ARG_WIDTH'(1) : f_arg;
                srst_d  = 1'b1;
              end
              OP_WAIT: begin
                if (f_arg != '0) begin
                  state_d = S_WAIT;
                  cnt_d   = f_arg;
                end
              end
              OP_END: begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end
              OP_RSVD: err_d = 1'b1;
              OP_NOP:  ;
            endcase
          end
        end
        S_WAIT: begin
          if (cnt_q <= ARG_WIDTH'(1)) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - ARG_WIDTH'(1);
          end
        end
        S_RST: begin
          if (cnt_q <= ARG_WIDTH'(1)) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d  = cnt_q - ARG_WIDTH'(1);
            srst_d = 1'b1;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= S_IDLE;
      cnt_q              <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      err_sticky         <= 1'b0;
      shifter_reset      <= 1'b0;
      delay_value        <= '0;
      delay_set          <= 1'b0;
      event_value        <= '0;
      event_set          <= 1'b0;
      event_polarity_set <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      busy               <= busy_d;
      done               <= done_d;
      err_sticky         <= err_d;
      shifter_reset      <= srst_d;
      delay_value        <= dval_d;
      delay_set          <= dset_d;
      event_value        <= eval_d;
      event_set          <= eset_d;
      event_polarity_set <= pol_d;
    end
  end

endmodule
